// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   ifu_state_e : fetch FSM state (RUN, HALT)
//   FC_*        : fault cause encodings reported on fault_cause
//   PC_STEP     : sequential PC increment in bytes
//   NOP_INSTR   : canonical RISC-V NOP (addi x0, x0, 0) held in IF/ID after reset
package ifu_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } ifu_state_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISALIGN = 2'd1;
  localparam logic [1:0] FC_RANGE    = 2'd2;
  localparam logic [1:0] FC_ZERO     = 2'd3;

  localparam logic [63:0] PC_STEP   = 64'd4;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/ifu_fault_check.sv
// ifu_fault_check: combinational fetch-fault classifier.
//   pc        in  64  address being fetched
//   instr     in  32  word returned for pc
//   fault_hit out  1  a fault is present on this fetch
//   cause     out  2  highest-priority fault cause (misaligned > range > zero)
// Parameter MEM_SIZE: instruction memory size in bytes (>= 4).
// Optional macro IFU_ZERO_INSTR_FAULT_EN: treat an all-zero word at an aligned,
// in-range PC as fault cause FC_ZERO.
module ifu_fault_check
  import ifu_pkg::*;
#(
  parameter logic [63:0] MEM_SIZE = 64'd4095
) (
  input  logic [63:0] pc,
  input  logic [31:0] instr,
  output logic        fault_hit,
  output logic [1:0]  cause
);

  // Highest byte address at which a full 32-bit word still fits.
  localparam logic [63:0] LAST_PC = MEM_SIZE - 64'd4;

`ifndef IFU_ZERO_INSTR_FAULT_EN
  logic unused_instr;
  assign unused_instr = ^instr;
`endif

  always_comb begin
    fault_hit = 1'b0;
    cause     = FC_NONE;
    if (pc[1:0] != 2'b00) begin
      fault_hit = 1'b1;
      cause     = FC_MISALIGN;
    end else if (pc > LAST_PC) begin
      fault_hit = 1'b1;
      cause     = FC_RANGE;
    end
`ifdef IFU_ZERO_INSTR_FAULT_EN
    else if (instr == 32'h0) begin
      fault_hit = 1'b1;
      cause     = FC_ZERO;
    end
`endif
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IF stage owning the PC and the IF/ID register.
//   clk, reset     in      clock, synchronous active-high reset
//   imem_addr      out 64  fetch address (equals pc_q, combinational)
//   imem_instr     in  32  instruction word for imem_addr
//   stall          in   1  hold PC and IF/ID
//   branch_taken   in   1  redirect to branch_target, squash current fetch
//   branch_target  in  64  redirect PC
//   if_valid/if_pc/if_instr out  IF/ID register
//   fault/fault_cause/fault_pc out  sticky fault record
//   halted         out  1  FSM in HALT
// Parameters: RESET_PC, MEM_SIZE.
// Optional macro IFU_ZERO_INSTR_FAULT_EN (see ifu_fault_check).
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] MEM_SIZE = 64'd4095
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [63:0] fault_pc,
  output logic        halted
);

  ifu_state_e  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        if_valid_d;
  logic [63:0] if_pc_d;
  logic [31:0] if_instr_d;
  logic        fault_d;
  logic [1:0]  fault_cause_d;
  logic [63:0] fault_pc_d;

  logic        chk_hit;
  logic [1:0]  chk_cause;

  ifu_fault_check #(
    .MEM_SIZE(MEM_SIZE)
  ) u_fault_check (
    .pc        (pc_q),
    .instr     (imem_instr),
    .fault_hit (chk_hit),
    .cause     (chk_cause)
  );

  assign imem_addr = pc_q;
  assign halted    = (state_q == HALT);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid;
    if_pc_d       = if_pc;
    if_instr_d    = if_instr;
    fault_d       = fault;
    fault_cause_d = fault_cause;
    fault_pc_d    = fault_pc;
    case (state_q)
      RUN: begin
        // Redirect wins over stall and over any fault on the wrong-path fetch.
        if (branch_taken) begin
          pc_d       = branch_target;
          if_valid_d = 1'b0;
        end else if (stall) begin
          // hold everything
        end else if (chk_hit) begin
          fault_d       = 1'b1;
          fault_cause_d = chk_cause;
          fault_pc_d    = pc_q;
          if_valid_d    = 1'b0;
          state_d       = HALT;
        end else begin
          if_pc_d    = pc_q;
          if_instr_d = imem_instr;
          if_valid_d = 1'b1;
          pc_d       = pc_q + PC_STEP;
        end
      end
      HALT: begin
        if_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_instr    <= NOP_INSTR;
      fault       <= 1'b0;
      fault_cause <= FC_NONE;
      fault_pc    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_valid    <= if_valid_d;
      if_pc       <= if_pc_d;
      if_instr    <= if_instr_d;
      fault       <= fault_d;
      fault_cause <= fault_cause_d;
      fault_pc    <= fault_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: self-checking bench for instr_fetch_unit with a
// big-endian byte memory model and a fetch scoreboard.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [63:0] fault_pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_t;

  fetch_t      sb[$];
  logic [63:0] exp_pc;
  logic [7:0]  mem [0:4095];

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC(64'h0),
    .MEM_SIZE(64'd4095)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .fault         (fault),
    .fault_cause   (fault_cause),
    .fault_pc      (fault_pc),
    .halted        (halted)
  );

  // Instruction memory: big-endian words, combinational read.
  always_comb begin
    if (imem_addr <= 64'd4092)
      imem_instr = {mem[imem_addr[11:0]], mem[imem_addr[11:0] + 12'd1],
                    mem[imem_addr[11:0] + 12'd2], mem[imem_addr[11:0] + 12'd3]};
    else
      imem_instr = 32'hFFFF_FFFF;
  end

  function automatic logic [31:0] word_at(input logic [63:0] a);
    if (a <= 64'd4092)
      return {mem[a[11:0]], mem[a[11:0] + 12'd1], mem[a[11:0] + 12'd2], mem[a[11:0] + 12'd3]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic b, input logic [63:0] t);
    stall         = s;
    branch_taken  = b;
    branch_target = t;
  endtask

  // One sequential fetch: expectation queued at drive time, checked after the edge.
  task automatic fetch_one();
    fetch_t e;
    drive(1'b0, 1'b0, 64'h0);
    sb.push_back('{pc: exp_pc, instr: word_at(exp_pc)});
    tick();
    e = sb.pop_front();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr) begin
      errors++;
      $display("FAIL fetch: got v=%0b pc=%h instr=%h, expected v=1 pc=%h instr=%h",
               if_valid, if_pc, if_instr, e.pc, e.instr);
    end
    exp_pc = exp_pc + 64'd4;
    checks++;
    if (imem_addr !== exp_pc) begin
      errors++;
      $display("FAIL fetch_next_pc: got %h expected %h", imem_addr, exp_pc);
    end
  endtask

  task automatic test_reset(input string tag);
    drive(1'b0, 1'b0, 64'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_pc = 64'h0;
    checks++;
    if (if_valid !== 1'b0 || if_pc !== 64'h0 || if_instr !== 32'h00000013) begin
      errors++;
      $display("FAIL reset_ifid(%s): got v=%0b pc=%h instr=%h, expected v=0 pc=0 instr=00000013",
               tag, if_valid, if_pc, if_instr);
    end
    checks++;
    if (fault !== 1'b0 || fault_cause !== 2'd0 || fault_pc !== 64'h0 || halted !== 1'b0 ||
        imem_addr !== 64'h0) begin
      errors++;
      $display("FAIL reset_fault(%s): got f=%0b c=%0d fpc=%h h=%0b addr=%h, expected all 0",
               tag, fault, fault_cause, fault_pc, halted, imem_addr);
    end
  endtask

  task automatic test_seq_fetch();
    fetch_one();
    checks++;
    if (if_instr !== 32'h00000093) begin
      errors++;
      $display("FAIL seq_word0: got %h expected 00000093", if_instr);
    end
    fetch_one();
    checks++;
    if (if_pc !== 64'h4 || if_instr !== 32'h00100093) begin
      errors++;
      $display("FAIL seq_word1: got pc=%h instr=%h expected pc=4 instr=00100093", if_pc, if_instr);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 64'h0);
      tick();
      checks++;
      if (imem_addr !== 64'h8 || if_pc !== 64'h4 || if_instr !== 32'h00100093 || if_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got addr=%h pc=%h instr=%h v=%0b expected addr=8 pc=4 instr=00100093 v=1",
                 i, imem_addr, if_pc, if_instr, if_valid);
      end
    end
    fetch_one();
  endtask

  task automatic test_branch();
    drive(1'b1, 1'b1, 64'h40);
    tick();
    checks++;
    if (imem_addr !== 64'h40 || if_valid !== 1'b0 || if_pc !== 64'h8 || if_instr !== word_at(64'h8)) begin
      errors++;
      $display("FAIL branch_redirect: got addr=%h v=%0b pc=%h instr=%h expected addr=40 v=0 pc=8 instr=%h",
               imem_addr, if_valid, if_pc, if_instr, word_at(64'h8));
    end
    exp_pc = 64'h40;
    fetch_one();
  endtask

  task automatic test_zero();
    drive(1'b0, 1'b1, 64'h10);
    tick();
    exp_pc = 64'h10;
`ifdef IFU_ZERO_INSTR_FAULT_EN
    drive(1'b0, 1'b0, 64'h0);
    tick();
    checks++;
    if (fault !== 1'b1 || fault_cause !== 2'd3 || fault_pc !== 64'h10 || halted !== 1'b1 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_fault: got f=%0b c=%0d fpc=%h h=%0b v=%0b expected f=1 c=3 fpc=10 h=1 v=0",
               fault, fault_cause, fault_pc, halted, if_valid);
    end
`else
    fetch_one();
    checks++;
    if (if_instr !== 32'h0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL zero_latched: got instr=%h f=%0b expected instr=0 f=0", if_instr, fault);
    end
`endif
    test_reset("after_zero");
  endtask

  task automatic test_misaligned();
    drive(1'b0, 1'b1, 64'h42);
    tick();
    drive(1'b0, 1'b0, 64'h0);
    tick();
    checks++;
    if (fault !== 1'b1 || fault_cause !== 2'd1 || fault_pc !== 64'h42 || halted !== 1'b1 ||
        if_valid !== 1'b0 || imem_addr !== 64'h42) begin
      errors++;
      $display("FAIL misalign: got f=%0b c=%0d fpc=%h h=%0b v=%0b addr=%h expected f=1 c=1 fpc=42 h=1 v=0 addr=42",
               fault, fault_cause, fault_pc, halted, if_valid, imem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 64'h80);
      tick();
      checks++;
      if (imem_addr !== 64'h42 || halted !== 1'b1 || if_valid !== 1'b0 || fault_cause !== 2'd1) begin
        errors++;
        $display("FAIL halt_ignores_branch[%0d]: got addr=%h h=%0b v=%0b c=%0d expected addr=42 h=1 v=0 c=1",
                 i, imem_addr, halted, if_valid, fault_cause);
      end
    end
    test_reset("in_halt");
  endtask

  task automatic test_range();
    drive(1'b0, 1'b1, 64'hFF4);
    tick();
    exp_pc = 64'hFF4;
    fetch_one();
    fetch_one();
    drive(1'b0, 1'b0, 64'h0);
    tick();
    checks++;
    if (fault !== 1'b1 || fault_cause !== 2'd2 || fault_pc !== 64'hFFC || halted !== 1'b1 ||
        if_valid !== 1'b0 || if_pc !== 64'hFF8) begin
      errors++;
      $display("FAIL range: got f=%0b c=%0d fpc=%h h=%0b v=%0b pc=%h expected f=1 c=2 fpc=ffc h=1 v=0 pc=ff8",
               fault, fault_cause, fault_pc, halted, if_valid, if_pc);
    end
    test_reset("after_range");

    // Same out-of-range PC reached, but stalled and then squashed.
    drive(1'b0, 1'b1, 64'hFF8);
    tick();
    exp_pc = 64'hFF8;
    fetch_one();
    drive(1'b1, 1'b0, 64'h0);
    tick();
    checks++;
    if (fault !== 1'b0 || halted !== 1'b0 || imem_addr !== 64'hFFC) begin
      errors++;
      $display("FAIL range_stalled: got f=%0b h=%0b addr=%h expected f=0 h=0 addr=ffc", fault, halted, imem_addr);
    end
    drive(1'b0, 1'b1, 64'h20);
    tick();
    checks++;
    if (fault !== 1'b0 || halted !== 1'b0 || imem_addr !== 64'h20 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL range_wrong_path: got f=%0b h=%0b addr=%h v=%0b expected f=0 h=0 addr=20 v=0",
               fault, halted, imem_addr, if_valid);
    end
    exp_pc = 64'h20;
    fetch_one();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    for (int unsigned a = 0; a < 4096; a += 4) begin
      if (a == 0)
        w = 32'h00000093;
      else if (a == 4)
        w = 32'h00100093;
      else if (a == 16)
        w = 32'h00000000;
      else
        w = (a << 20) | 32'h113;
      mem[a]     = w[31:24];
      mem[a + 1] = w[23:16];
      mem[a + 2] = w[15:8];
      mem[a + 3] = w[7:0];
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 64'h0);
    exp_pc = 64'h0;
    @(negedge clk);

    test_reset("power_on");
    test_seq_fetch();
    test_stall();
    test_branch();
    test_zero();
    test_misaligned();
    test_range();

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
